// File: rtl/led_zone_scheduler_pkg.sv
// led_sched_pkg
// Shared constants and types for the LED zone readout sequencer.
// Zone grid geometry (24 x 15 zones of 53 x 53 px), address/data
// widths of the zone-maximum memory and the sequencer state type.
package led_sched_pkg;

    localparam int ZONE_COLS = 24;
    localparam int ZONE_ROWS = 15;
    localparam int ZONE_PIX  = 53;
    localparam int ZONE_NUM  = ZONE_COLS * ZONE_ROWS;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_SEND
    } sched_state_t;

endpackage

// File: rtl/led_zone_scheduler_if.sv
// led_zone_scheduler_if
// Valid/ready beat stream from the zone sequencer to the LED driver.
//   led_valid : beat valid (source)
//   led_data  : zone maximum value (source)
//   led_idx   : zone index of the beat (source)
//   led_last  : high on the final zone of the frame (source)
//   led_ready : LED driver accepts the beat (sink)
interface led_zone_scheduler_if #(
    parameter int ADDR_W = led_sched_pkg::ADDR_W,
    parameter int DATA_W = led_sched_pkg::DATA_W
);

    logic              led_valid;
    logic [DATA_W-1:0] led_data;
    logic [ADDR_W-1:0] led_idx;
    logic              led_last;
    logic              led_ready;

    modport master (
        output led_valid,
        output led_data,
        output led_idx,
        output led_last,
        input  led_ready
    );

    modport slave (
        input  led_valid,
        input  led_data,
        input  led_idx,
        input  led_last,
        output led_ready
    );

endinterface

// File: rtl/led_zone_scheduler_sync_edge_det.sv
// sync_edge_det
// Registered rising-edge detector. The delayed copy of the input has a
// parameterised reset value so that a level already high when reset is
// released can be kept from counting as an edge.
//   clk  : clock
//   rst  : synchronous active-high reset
//   sig  : input level
//   rise : one-cycle registered pulse, one clock after sig goes 0->1
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    // Delay the level one cycle and flag a low-to-high step.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d <= RST_VAL;
            rise  <= 1'b0;
        end else begin
            sig_d <= sig;
            rise  <= sig & ~sig_d;
        end
    end

endmodule

// File: rtl/led_zone_scheduler.sv
// led_zone_scheduler
// Per-frame readout sequencer for the ping-pong zone-maximum memory.
// On each frame start it swaps banks, reads every zone of the finished
// bank in order, streams each value to the LED driver and clears the
// zone once the beat has been accepted.
//   I_pix_clk  : pixel clock
//   I_rst      : synchronous active-high reset
//   I_vs       : vertical sync, active high
//   I_enable   : start permission, sampled at frame start only
//   O_bank_sel : bank written by the accumulator; this block reads the other
//   O_rd_en    : zone read strobe, O_rd_addr its address
//   I_rd_data  : read data, valid the cycle after O_rd_en
//   O_clr_en   : write-zero strobe, O_clr_addr the zone to clear
//   led        : valid/ready beat stream (data, idx, last)
//   O_busy     : readout in progress
//   O_overrun  : one-cycle pulse when a frame start arrives while busy
module led_zone_scheduler
    import led_sched_pkg::*;
#(
    parameter int ZONE_NUM = led_sched_pkg::ZONE_NUM,
    parameter int ADDR_W   = led_sched_pkg::ADDR_W,
    parameter int DATA_W   = led_sched_pkg::DATA_W
) (
    input  logic                 I_pix_clk,
    input  logic                 I_rst,
    input  logic                 I_vs,
    input  logic                 I_enable,
    output logic                 O_bank_sel,
    output logic                 O_rd_en,
    output logic [ADDR_W-1:0]    O_rd_addr,
    input  logic [DATA_W-1:0]    I_rd_data,
    output logic                 O_clr_en,
    output logic [ADDR_W-1:0]    O_clr_addr,
    led_zone_scheduler_if.master led,
    output logic                 O_busy,
    output logic                 O_overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ZONE_NUM - 1);

    sched_state_t      state;
    logic [ADDR_W-1:0] idx;
    logic              frame_start;

    logic              led_valid_q;
    logic [DATA_W-1:0] led_data_q;
    logic [ADDR_W-1:0] led_idx_q;
    logic              led_last_q;

    // The delayed vs resets high so that vs already high at reset
    // release does not look like a frame start.
    sync_edge_det #(
        .RST_VAL (1'b1)
    ) u_vs_edge (
        .clk  (I_pix_clk),
        .rst  (I_rst),
        .sig  (I_vs),
        .rise (frame_start)
    );

    assign led.led_valid = led_valid_q;
    assign led.led_data  = led_data_q;
    assign led.led_idx   = led_idx_q;
    assign led.led_last  = led_last_q;

    // Readout sequencer: each zone takes READ (strobe out), CAPT (data
    // back from memory) and SEND (wait for the LED driver). The clear of
    // a zone is issued only once its beat has been accepted.
    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            O_bank_sel  <= 1'b0;
            O_rd_en     <= 1'b0;
            O_rd_addr   <= '0;
            O_clr_en    <= 1'b0;
            O_clr_addr  <= '0;
            led_valid_q <= 1'b0;
            led_data_q  <= '0;
            led_idx_q   <= '0;
            led_last_q  <= 1'b0;
            O_busy      <= 1'b0;
            O_overrun   <= 1'b0;
        end else begin
            O_clr_en  <= 1'b0;
            // A start during a readout is reported and otherwise ignored.
            O_overrun <= frame_start && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (frame_start && I_enable) begin
                        O_bank_sel <= ~O_bank_sel;
                        idx        <= '0;
                        O_busy     <= 1'b1;
                        O_rd_en    <= 1'b1;
                        O_rd_addr  <= '0;
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    O_rd_en <= 1'b0;
                    state   <= ST_CAPT;
                end
                ST_CAPT: begin
                    led_data_q  <= I_rd_data;
                    led_idx_q   <= idx;
                    led_last_q  <= (idx == LAST_IDX);
                    led_valid_q <= 1'b1;
                    state       <= ST_SEND;
                end
                ST_SEND: begin
                    if (led_valid_q && led.led_ready) begin
                        led_valid_q <= 1'b0;
                        O_clr_en    <= 1'b1;
                        O_clr_addr  <= idx;
                        if (idx == LAST_IDX) begin
                            O_busy <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            idx       <= idx + ADDR_W'(1);
                            O_rd_en   <= 1'b1;
                            O_rd_addr <= idx + ADDR_W'(1);
                            state     <= ST_READ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_zone_scheduler.sv
// tb_led_zone_scheduler
// Randomised scoreboard bench for led_zone_scheduler. A two-bank memory
// model stands in for the zone-maximum RAM; each accepted frame start
// fills the finished bank with random values and queues the beats and
// clears the readout must produce. A negedge monitor pops and compares.
module tb_led_zone_scheduler;
    import led_sched_pkg::*;

    localparam int NZ = ZONE_NUM;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } beat_t;

    logic              pix_clk = 1'b0;
    logic              rst;
    logic              vs;
    logic              enable;
    logic              bank_sel;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;
    logic              overrun;

    led_zone_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) led_bus ();

    led_zone_scheduler dut (
        .I_pix_clk  (pix_clk),
        .I_rst      (rst),
        .I_vs       (vs),
        .I_enable   (enable),
        .O_bank_sel (bank_sel),
        .O_rd_en    (rd_en),
        .O_rd_addr  (rd_addr),
        .I_rd_data  (rd_data),
        .O_clr_en   (clr_en),
        .O_clr_addr (clr_addr),
        .led        (led_bus.master),
        .O_busy     (busy),
        .O_overrun  (overrun)
    );

    always #5 pix_clk = ~pix_clk;

    int total = 0;
    int bad   = 0;

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] clr_q[$];
    logic              exp_bank = 1'b0;
    int                ready_mode = 0;

    logic [DATA_W-1:0] mem [2][NZ];
    logic [DATA_W-1:0] next_frame [NZ];
    logic              fill_bank = 1'b0;
    int                fill_seq  = 0;
    int                fill_seen = 0;

    int neg_cnt = 0, last_acc = -10, beats_seen = 0, ovr_cycles = 0;
    int rd_cycles = 0, busy_cycles = 0;
    int vs_rise_cnt = 0, busy_rise_cnt = 0, busy_fall_cnt = 0, first_valid_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pix_clk);
            #1;
        end
    endtask

    // Memory model: the accumulator side loads a new frame into the
    // bank it owns; the sequencer side reads and clears the other bank.
    always @(posedge pix_clk) begin
        if (fill_seq != fill_seen) begin
            for (int i = 0; i < NZ; i++) mem[fill_bank][i] <= next_frame[i];
            fill_seen <= fill_seq;
        end
        if (rd_en) rd_data <= mem[~bank_sel][rd_addr];
        if (clr_en) mem[~bank_sel][clr_addr] <= '0;
    end

    // LED driver ready pattern: 0 always ready, 1 random, 2 a 10-cycle
    // stall at zone 5 followed by alternating ready.
    initial begin : ready_gen
        int   stall_cnt;
        logic stall_done;
        stall_cnt = 0;
        stall_done = 1'b0;
        led_bus.led_ready = 1'b1;
        forever begin
            @(posedge pix_clk);
            #1;
            case (ready_mode)
                1: led_bus.led_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!stall_done && led_bus.led_valid && led_bus.led_idx == ADDR_W'(5)) begin
                        led_bus.led_ready = 1'b0;
                        stall_cnt++;
                        if (stall_cnt == 10) stall_done = 1'b1;
                    end else if (stall_done) begin
                        led_bus.led_ready = ~led_bus.led_ready;
                    end else begin
                        led_bus.led_ready = 1'b1;
                    end
                end
                default: begin
                    led_bus.led_ready = 1'b1;
                    stall_cnt = 0;
                    stall_done = 1'b0;
                end
            endcase
        end
    end

    // Monitor: checks beats against the scoreboard on acceptance, holds
    // stalled beats stable, checks clears and records event timestamps.
    always @(negedge pix_clk) begin : monitor
        beat_t cur;
        beat_t e;
        beat_t held;
        logic  held_valid;
        logic  prev_vs, prev_busy, prev_valid, armed;
        neg_cnt++;
        cur = '{data: led_bus.led_data, idx: led_bus.led_idx, last: led_bus.led_last};
        if (rst) begin
            held_valid = 1'b0;
            armed = 1'b0;
        end else begin
            if (vs && !prev_vs) vs_rise_cnt = neg_cnt;
            if (busy && !prev_busy) begin
                busy_rise_cnt = neg_cnt;
                armed = 1'b1;
            end
            if (!busy && prev_busy) busy_fall_cnt = neg_cnt;
            if (led_bus.led_valid && !prev_valid && armed) begin
                first_valid_cnt = neg_cnt;
                armed = 1'b0;
            end
            if (overrun) ovr_cycles++;
            if (rd_en) rd_cycles++;
            if (busy) busy_cycles++;
            if (clr_en) begin
                checkOutput("clr_expected", clr_q.size() != 0, 1);
                if (clr_q.size() != 0) checkOutput("clr_addr", clr_addr, clr_q.pop_front());
                checkOutput("clr_after_accept", neg_cnt, last_acc + 1);
            end
            if (led_bus.led_valid) begin
                if (held_valid) checkOutput("stall_stable", cur, held);
                if (led_bus.led_ready) begin
                    checkOutput("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("beat_idx", cur.idx, e.idx);
                        checkOutput("beat_data", cur.data, e.data);
                        checkOutput("beat_last", cur.last, e.last);
                    end
                    last_acc = neg_cnt;
                    beats_seen++;
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held = cur;
                end
            end else begin
                held_valid = 1'b0;
            end
        end
        prev_vs = vs;
        prev_busy = busy;
        prev_valid = led_bus.led_valid;
    end

    // Issue one vs rise. If the reference model says the start will be
    // taken, load a fresh random frame into the finished bank and queue
    // the 360 beats and clears it must produce.
    task automatic applyStimulus(input logic en);
        if (en && exp_q.size() == 0) begin
            for (int i = 0; i < NZ; i++) begin
                next_frame[i] = DATA_W'($urandom);
                exp_q.push_back('{data: next_frame[i], idx: ADDR_W'(i), last: (i == NZ - 1)});
                clr_q.push_back(ADDR_W'(i));
            end
            fill_bank = exp_bank;
            fill_seq++;
            tick(1);
            exp_bank = ~exp_bank;
        end
        vs = 1'b1;
        tick(3);
        vs = 1'b0;
    endtask

    task automatic waitFrameDone();
        int n;
        int nz;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            tick(1);
            n++;
        end
        checkOutput("frame_done_in_time", n < 5000, 1);
        tick(2);
        checkOutput("clr_queue_empty", clr_q.size(), 0);
        nz = 0;
        for (int i = 0; i < NZ; i++) if (mem[~exp_bank][i] != '0) nz++;
        checkOutput("read_bank_cleared", nz, 0);
        checkOutput("bank_sel", bank_sel, exp_bank);
    endtask

    task automatic waitIdx(input int target);
        int n;
        n = 0;
        while (!(led_bus.led_valid && led_bus.led_idx == ADDR_W'(target)) && n < 3000) begin
            tick(1);
            n++;
        end
        checkOutput("reached_idx", n < 3000, 1);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_ctrl"}, {bank_sel, rd_en, rd_addr, clr_en, clr_addr, busy, overrun}, 0);
        checkOutput({name, "_led"}, {led_bus.led_valid, led_bus.led_data, led_bus.led_idx, led_bus.led_last}, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int b0, r0, bz, o0;
        rst = 1'b1;
        vs = 1'b0;
        enable = 1'b1;
        tick(3);
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick(2);

        $display("[TB] full frame, ready held high");
        checkOutput("bank_before", bank_sel, 0);
        b0 = beats_seen;
        applyStimulus(1'b1);
        waitFrameDone();
        checkOutput("beats_full", beats_seen - b0, NZ);
        checkOutput("valid_latency", first_valid_cnt - vs_rise_cnt, 4);
        checkOutput("busy_cycles", busy_fall_cnt - busy_rise_cnt, 3 * NZ);

        $display("[TB] stall at zone 5 then alternating ready");
        ready_mode = 2;
        b0 = beats_seen;
        applyStimulus(1'b1);
        waitFrameDone();
        checkOutput("beats_stall", beats_seen - b0, NZ);
        ready_mode = 0;

        $display("[TB] second frame start at zone 100");
        b0 = beats_seen;
        applyStimulus(1'b1);
        waitIdx(100);
        o0 = ovr_cycles;
        applyStimulus(1'b1);
        tick(2);
        checkOutput("overrun_pulse", ovr_cycles - o0, 1);
        checkOutput("bank_after_overrun", bank_sel, exp_bank);
        waitFrameDone();
        checkOutput("beats_overrun", beats_seen - b0, NZ);

        $display("[TB] frame start with enable low");
        enable = 1'b0;
        r0 = rd_cycles;
        bz = busy_cycles;
        applyStimulus(1'b0);
        tick(10);
        checkOutput("disabled_rd", rd_cycles - r0, 0);
        checkOutput("disabled_busy", busy_cycles - bz, 0);
        checkOutput("disabled_bank", bank_sel, exp_bank);
        enable = 1'b1;

        $display("[TB] enable dropped at zone 50, random ready");
        ready_mode = 1;
        b0 = beats_seen;
        applyStimulus(1'b1);
        waitIdx(50);
        enable = 1'b0;
        waitFrameDone();
        checkOutput("beats_enable_drop", beats_seen - b0, NZ);
        enable = 1'b1;
        ready_mode = 0;

        $display("[TB] reset at zone 100");
        applyStimulus(1'b1);
        waitIdx(100);
        rst = 1'b1;
        exp_q.delete();
        clr_q.delete();
        exp_bank = 1'b0;
        tick(1);
        checkIdleOutputs("midreset");
        rst = 1'b0;
        tick(2);
        b0 = beats_seen;
        applyStimulus(1'b1);
        waitFrameDone();
        checkOutput("beats_after_reset", beats_seen - b0, NZ);

        $display("[TB] vs held high through reset release");
        rst = 1'b1;
        vs = 1'b1;
        tick(3);
        rst = 1'b0;
        exp_bank = 1'b0;
        r0 = rd_cycles;
        bz = busy_cycles;
        tick(10);
        checkOutput("vs_high_rd", rd_cycles - r0, 0);
        checkOutput("vs_high_busy", busy_cycles - bz, 0);
        checkOutput("vs_high_bank", bank_sel, 0);
        vs = 1'b0;
        tick(2);
        b0 = beats_seen;
        applyStimulus(1'b1);
        waitFrameDone();
        checkOutput("beats_after_vs_low", beats_seen - b0, NZ);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
